// File: rtl/pipe_ctrl_if.sv
// Flush/hold/redirect bundle between pipe_ctrl and the EX, pc_reg, if_id and id_ex stages.
// Handshake: jump_en_o is a single-cycle strobe that qualifies jump_addr_o; hold_o is a level.

`ifndef RV32_ADDR_WIDTH
`define RV32_ADDR_WIDTH 32
`endif
`ifndef RST_INST_ADDR
`define RST_INST_ADDR 32'h0000_0000
`endif

interface pipe_ctrl_if;
  logic                        jump_en_i;
  logic [`RV32_ADDR_WIDTH-1:0] jump_addr_i;
  logic                        hold_req_i;
  logic                        done_i;
  logic                        jump_en_o;
  logic [`RV32_ADDR_WIDTH-1:0] jump_addr_o;
  logic                        pipeline_flush_o;
  logic                        hold_o;
  logic                        hold_timeout_o;
  logic [1:0]                  state_dbg;

  modport master (
    input  jump_en_i, jump_addr_i, hold_req_i, done_i,
    output jump_en_o, jump_addr_o, pipeline_flush_o, hold_o, hold_timeout_o, state_dbg
  );

  modport slave (
    output jump_en_i, jump_addr_i, hold_req_i, done_i,
    input  jump_en_o, jump_addr_o, pipeline_flush_o, hold_o, hold_timeout_o, state_dbg
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: IDLE/FLUSH/HOLD sequencer producing flush, hold and PC redirect.
// Optional hold watchdog enabled by defining PIPE_CTRL_HOLD_TIMEOUT_EN.

`ifndef RV32_ADDR_WIDTH
`define RV32_ADDR_WIDTH 32
`endif
`ifndef RST_INST_ADDR
`define RST_INST_ADDR 32'h0000_0000
`endif

module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned HOLD_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  pipe_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || HOLD_TIMEOUT < 2 || HOLD_TIMEOUT > 255)
  begin : g_param_check
    $error("pipe_ctrl: FLUSH_CYCLES or HOLD_TIMEOUT out of range");
  end

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wd_fire;
  logic       jump_take;

`ifdef PIPE_CTRL_HOLD_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(HOLD_TIMEOUT - 2);

  logic [7:0] wd_q, wd_d;
  logic       to_q, to_d;

  // Fires on the HOLD cycle in which the count would reach HOLD_TIMEOUT-1.
  assign wd_fire = (state_q == ST_HOLD) && !bus.done_i && (wd_q == WD_LAST);

  always_comb begin
    wd_d = 8'd0;
    to_d = to_q | wd_fire;
    if (state_q == ST_HOLD && !bus.done_i) begin
      wd_d = wd_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= 8'd0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end

  assign bus.hold_timeout_o = to_q;
`else
  assign wd_fire            = 1'b0;
  assign bus.hold_timeout_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.jump_en_i) begin
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end
        end else if (bus.hold_req_i && !bus.done_i) begin
          state_d = ST_HOLD;
        end
      end
      ST_FLUSH: begin
        // hold_req_i is dropped here: EX is executing a flushed NOP.
        if (bus.jump_en_i) begin
          cnt_d = FLUSH_RELOAD;
        end else if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (bus.done_i || wd_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs are gated by rst_n so an asserted reset forces them low even while inputs are active.
  assign jump_take = rst_n && bus.jump_en_i && (state_q != ST_HOLD);

  assign bus.jump_en_o        = jump_take;
  assign bus.jump_addr_o      = jump_take ? bus.jump_addr_i : `RST_INST_ADDR;
  assign bus.pipeline_flush_o = jump_take || (state_q == ST_FLUSH) || wd_fire;
  assign bus.hold_o           = rst_n &&
                                (((state_q == ST_HOLD) && !bus.done_i && !wd_fire) ||
                                 ((state_q == ST_IDLE) && bus.hold_req_i && !bus.done_i &&
                                  !bus.jump_en_i));
  assign bus.state_dbg        = state_q;

endmodule
